// File: rtl/poly_horner_eval_if.sv
// rtl/poly_horner_eval_if.sv - operand/result bundle for the Horner polynomial evaluator
//
// Signals:
//   start    request to evaluate, honoured only while the evaluator is idle
//   X        evaluation point (W bits)
//   COEF     packed coefficients, c_0 in the low W bits, c_DEG in the high W bits
//   busy     evaluation in progress
//   done     one-cycle pulse, RESULT/overflow valid from this cycle
//   RESULT   P(X) mod 2^OW
//   overflow some Horner step exceeded 2^OW-1
// Modports: master drives the request side, slave is the evaluator.
interface poly_horner_eval_if #(
  parameter int W   = 8,
  parameter int DEG = 2,
  parameter int OW  = 16
) ();
  logic                   start;
  logic [W-1:0]           X;
  logic [(DEG+1)*W-1:0]   COEF;
  logic                   busy;
  logic                   done;
  logic [OW-1:0]          RESULT;
  logic                   overflow;

  modport master (
    output start, X, COEF,
    input  busy, done, RESULT, overflow
  );

  modport slave (
    input  start, X, COEF,
    output busy, done, RESULT, overflow
  );
endinterface

// File: rtl/poly_horner_eval.sv
// rtl/poly_horner_eval.sv - unsigned polynomial evaluator using Horner's method
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  poly_horner_eval_if.slave: start/X/COEF in, busy/done/RESULT/overflow out
// One Horner step per cycle; a start accepted at edge k produces done in the
// cycle after edge k+DEG. Operands are latched so the caller may change them
// while busy.
module poly_horner_eval #(
  parameter int W   = 8,
  parameter int DEG = 2,
  parameter int OW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  poly_horner_eval_if.slave     bus
);

  localparam int TW = OW + W + 1;          // exact width of acc*x + c
  localparam int IW = $clog2(DEG + 1);

  typedef enum logic {IDLE, ITER} state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           x_q;
  logic [(DEG+1)*W-1:0]   coef_q;
  logic [OW-1:0]          acc_q;
  logic [IW-1:0]          idx_q;
  logic                   ovf_q;
  logic [OW-1:0]          result_q;
  logic                   overflow_q;
  logic                   done_q;

  logic                   busy_w;
  logic                   accept;
  logic                   last_step;
  logic [W-1:0]           c_sel;
  logic [TW-1:0]          t;
  logic                   step_ovf;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = ITER;
      ITER: if (idx_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    busy_w    = (state_q == ITER);
    accept    = (state_q == IDLE) && bus.start;
    last_step = (state_q == ITER) && (idx_q == '0);
  end

  // One Horner step at full precision; anything above bit OW-1 is overflow.
  always_comb begin
    c_sel    = coef_q[int'(idx_q)*W +: W];
    t        = TW'(acc_q) * TW'(x_q) + TW'(c_sel);
    step_ovf = |t[TW-1:OW];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q        <= '0;
      coef_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        x_q    <= bus.X;
        coef_q <= bus.COEF;
        acc_q  <= OW'(bus.COEF[DEG*W +: W]);
        idx_q  <= IW'(DEG - 1);
        ovf_q  <= 1'b0;
      end else if (busy_w) begin
        acc_q <= t[OW-1:0];
        ovf_q <= ovf_q | step_ovf;
        if (last_step) begin
          result_q   <= t[OW-1:0];
          overflow_q <= ovf_q | step_ovf;
          done_q     <= 1'b1;
        end else begin
          idx_q <= idx_q - 1'b1;
        end
      end
    end
  end

  assign bus.busy     = busy_w;
  assign bus.done     = done_q;
  assign bus.RESULT   = result_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// tb/tb_poly_horner_eval.sv - scoreboard bench for poly_horner_eval
module tb_poly_horner_eval;

  localparam int W   = 8;
  localparam int DEG = 2;
  localparam int OW  = 16;

  typedef struct {
    logic [OW-1:0] result;
    logic          ovf;
    int            when;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  poly_horner_eval_if #(.W(W), .DEG(DEG), .OW(OW)) bus ();

  poly_horner_eval #(.W(W), .DEG(DEG), .OW(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   neg_cnt  = 0;
  int   n_done   = 0;

  task automatic check(input string name, input longint act, input longint want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, want);
  endtask

  // Monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (bus.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result",   bus.RESULT,   e.result);
        check("overflow", bus.overflow, e.ovf);
        check("latency",  neg_cnt,      e.when);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [OW-1:0] r, input logic o, input int lat);
    exp_t e;
    e.result = r;
    e.ovf    = o;
    e.when   = neg_cnt + lat;
    exp_q.push_back(e);
  endtask

  task automatic set_ops(input logic [W-1:0] x, input logic [W-1:0] c2,
                         input logic [W-1:0] c1, input logic [W-1:0] c0);
    bus.X    = x;
    bus.COEF = {c2, c1, c0};
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    tick();
  endtask

  initial begin
    bus.start = 1'b0;
    set_ops(8'd0, 8'd0, 8'd0, 8'd0);

    // Reset / idle
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_busy",     bus.busy,     0);
    check("rst_done",     bus.done,     0);
    check("rst_result",   bus.RESULT,   0);
    check("rst_overflow", bus.overflow, 0);
    repeat (4) tick();
    check("idle_busy", bus.busy, 0);

    // Basic evaluation: 2*25 + 3*5 + 4 = 69
    set_ops(8'd5, 8'd2, 8'd3, 8'd4);
    bus.start = 1'b1;
    push(16'd69, 1'b0, DEG + 1);
    tick();
    bus.start = 1'b0;
    check("basic_busy_k", bus.busy, 1);
    tick();
    check("basic_busy_k1", bus.busy, 1);
    drain("basic_drain");

    // Overflow: 255*255+255 = 65280, then 65280*255+255 wraps to 511
    set_ops(8'd255, 8'd255, 8'd255, 8'd255);
    bus.start = 1'b1;
    push(16'd511, 1'b1, DEG + 1);
    tick();
    bus.start = 1'b0;
    drain("ovf_drain");

    // Busy protection: extra starts with X=9 must be ignored
    set_ops(8'd5, 8'd2, 8'd3, 8'd4);
    bus.start = 1'b1;
    push(16'd69, 1'b0, DEG + 1);
    tick();
    bus.X = 8'd9;
    tick();
    tick();
    bus.start = 1'b0;
    drain("busy_drain");

    // Back-to-back: start held high, accepted every DEG+1 cycles
    set_ops(8'd5, 8'd2, 8'd3, 8'd4);
    bus.start = 1'b1;
    push(16'd69, 1'b0, 3);
    push(16'd69, 1'b0, 6);
    push(16'd69, 1'b0, 9);
    repeat (7) tick();
    bus.start = 1'b0;
    drain("b2b_drain");

    // Reset mid-evaluation: no done, outputs cleared
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("mid_rst_busy",     bus.busy,     0);
    check("mid_rst_result",   bus.RESULT,   0);
    check("mid_rst_overflow", bus.overflow, 0);

    // Recovery after reset
    bus.start = 1'b1;
    push(16'd69, 1'b0, DEG + 1);
    tick();
    bus.start = 1'b0;
    drain("recover_drain");

    check("done_count", n_done, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/poly_horner_eval.md
Name: poly_horner_eval

Overview:
- Parametrised polynomial evaluator: P(x) = c_DEG·x^DEG + … + c_1·x + c_0, computed by Horner's method.
- Contains its own datapath and control FSM. The surrounding logic only drives start/operands and collects RESULT on done.
- Successor to the fixed three-coefficient, mux-steered evaluator. Adds generic width, generic degree, a start/done handshake and overflow reporting.
- Unsigned arithmetic throughout.

Parameters:
- W, 8: operand width of X and of each coefficient.
- DEG, 2: polynomial degree. Legal range 1..15.
- OW, 16: accumulator/RESULT width. Must satisfy OW >= W.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- start  input  1  request to evaluate; sampled only in IDLE.
- X  input  W  evaluation point; latched when start is accepted.
- COEF  input  (DEG+1)*W  packed coefficients. c_0 occupies the least-significant W bits and c_DEG the most-significant W bits. Latched when start is accepted.
- busy  output  1  high while an evaluation is in progress.
- done  output  1  one-cycle pulse; RESULT/overflow are valid from this cycle.
- RESULT  output  OW  P(X) mod 2^OW.
- overflow  output  1  high if any Horner step exceeded 2^OW−1 during the evaluation.

Behaviour:
- Reset (rst=0 at an edge):
  - FSM goes to IDLE; busy=0, done=0, RESULT=0, overflow=0.
  - Internal X/coef/acc/index registers are cleared.
  - Applies from any state. A reset mid-evaluation aborts it with no done pulse.
- FSM states: IDLE and ITER.
- IDLE:
  - On an edge with start=1: latch X and COEF, acc <= zero-extended c_DEG, idx <= DEG−1, ovf_int <= 0, busy <= 1, go to ITER.
  - Otherwise remain in IDLE.
- ITER, each edge:
  - Compute t = acc·Xl + c_idx at full precision (OW+W+1 bits).
  - acc <= t[OW−1:0]; ovf_int <= ovf_int | (t >= 2^OW).
  - If idx==0: RESULT <= new acc, overflow <= new ovf_int, done <= 1, busy <= 0, go to IDLE.
  - Else idx <= idx−1.
- Latency:
  - start sampled at edge k → busy high from edge k through edge k+DEG.
  - done high for exactly the cycle following edge k+DEG, i.e. DEG+1 cycles after the start edge.
  - Throughput: one evaluation per DEG+1 cycles.
- done is a single-cycle pulse. It is forced to 0 on every edge other than the final ITER edge.
- RESULT and overflow hold their values until the next done or reset.
- start while busy=1 is ignored; no queuing.
- Changes on X/COEF while busy have no effect (operands are latched).
- start high in the same cycle that done is high: FSM is already in IDLE, so the request is accepted at that edge (back-to-back operation). busy stays 0 for that one cycle only.
- DEG=1: exactly one ITER step; done two cycles after start.
- Arithmetic is unsigned. Wrap-around is modulo 2^OW at every step, so the final RESULT equals the exact P(X) mod 2^OW.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release → busy=0, done=0, RESULT=0, overflow=0. No activity without start.
- Basic evaluation, W=8, DEG=2, OW=16: c2=2, c1=3, c0=4, X=5, start pulsed at edge k → busy for edges k..k+2; done high in the cycle after edge k+2; RESULT=69, overflow=0.
- Overflow case, same parameters: c2=c1=c0=255, X=255 → step 1 gives acc=65280 with no overflow; step 2 wraps. Final RESULT=511, overflow=1, done after 3 cycles.
- Busy protection: start at edge k, re-assert start and change X to 9 at edges k+1 and k+2 → single done, RESULT still 69; the extra starts are ignored.
- Back-to-back: hold start=1 continuously with operands from the basic evaluation → done every 3rd cycle, each with RESULT=69.
- Reset mid-operation: start, then rst=0 at edge k+1 → no done pulse, all outputs 0. A new start after release yields RESULT=69 with normal latency.
